// File: rtl/bram_arbiter_pkg.sv
// Shared widths, FSM encoding and helpers for the BRAM arbiter and its memory.
package bram_arbiter_pkg;

   localparam int unsigned DW   = 16;
   localparam int unsigned AW   = 10;
   localparam int unsigned NREQ = 3;
   localparam int unsigned IW   = $clog2(NREQ);

   typedef enum logic {
      ST_ARB   = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   // Next requester index in round-robin order, wrapping at NREQ-1.
   function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] idx);
      return (idx == IW'(NREQ - 1)) ? '0 : idx + IW'(1);
   endfunction

endpackage

// File: rtl/bram_arbiter_if.sv
// Requester, clear-control and BRAM-port signals of the arbiter.
interface bram_arbiter_if;
   import bram_arbiter_pkg::*;

   logic [NREQ-1:0]    req;
   logic [NREQ-1:0]    we;
   logic [NREQ*AW-1:0] addr;
   logic [NREQ*DW-1:0] wdata;
   logic [NREQ-1:0]    gnt;
   logic [NREQ-1:0]    rvalid;
   logic [DW-1:0]      rdata;
   logic               clear_start;
   logic               clear_busy;
   logic               clear_done;
   logic [AW-1:0]      mem_addr;
   logic [DW-1:0]      mem_data;
   logic               mem_we;
   logic [DW-1:0]      mem_q;

   // Arbiter side.
   modport slave (
      input  req, we, addr, wdata, clear_start, mem_q,
      output gnt, rvalid, rdata, clear_busy, clear_done, mem_addr, mem_data, mem_we
   );

   // Requester / memory side.
   modport master (
      output req, we, addr, wdata, clear_start, mem_q,
      input  gnt, rvalid, rdata, clear_busy, clear_done, mem_addr, mem_data, mem_we
   );

endinterface

// File: rtl/bram_arbiter_rr_arbiter.sv
// Round-robin selector: search starts one past the last granted requester.
module rr_arbiter
   import bram_arbiter_pkg::*;
(
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   last,
   output logic [NREQ-1:0] gnt,
   output logic [IW-1:0]   idx,
   output logic            valid
);

   // Walk (last+1), (last+2), last; the first active request wins.
   always_comb begin
      logic [IW-1:0] cand;
      gnt   = '0;
      idx   = '0;
      valid = 1'b0;
      cand  = last;
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand = rr_next(cand);
         if (!valid && req[cand]) begin
            valid     = 1'b1;
            idx       = cand;
            gnt[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bram_arbiter.sv
// Three-way round-robin BRAM port arbiter with a whole-memory zero-fill mode.
module bram_arbiter
   import bram_arbiter_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   bram_arbiter_if.slave bus
);

   localparam logic [AW-1:0] CNT_LAST = '1;

   state_t          state, state_next;
   logic [IW-1:0]   last;
   logic [AW-1:0]   cnt, cnt_next;
   logic [NREQ-1:0] rvalid_q, rvalid_next;
   logic            busy_q, busy_next;
   logic            done_q, done_next;

   logic [NREQ-1:0] rr_gnt;
   logic [IW-1:0]   rr_idx;
   logic            rr_valid;

   logic [NREQ-1:0] gnt_c;
   logic [AW-1:0]   mem_addr_c;
   logic [DW-1:0]   mem_data_c;
   logic            mem_we_c;

   rr_arbiter u_rr (
      .req   (bus.req),
      .last  (last),
      .gnt   (rr_gnt),
      .idx   (rr_idx),
      .valid (rr_valid)
   );

   // State, round-robin pointer, clear counter and registered status outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_ARB;
         last     <= IW'(NREQ - 1);
         cnt      <= '0;
         rvalid_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state    <= state_next;
         cnt      <= cnt_next;
         rvalid_q <= rvalid_next;
         busy_q   <= busy_next;
         done_q   <= done_next;
         if (|gnt_c) begin
            last <= rr_idx;
         end
      end
   end

   // Next state, BRAM port mux and next values of the registered outputs.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      gnt_c      = '0;
      mem_addr_c = '0;
      mem_data_c = '0;
      mem_we_c   = 1'b0;
      done_next  = 1'b0;
      case (state)
         ST_ARB: begin
            gnt_c      = rr_gnt;
            mem_addr_c = bus.addr[32'(rr_idx) * AW +: AW];
            mem_data_c = bus.wdata[32'(rr_idx) * DW +: DW];
            mem_we_c   = rr_valid & bus.we[rr_idx];
            if (bus.clear_start) begin
               state_next = ST_CLEAR;
               cnt_next   = '0;
            end
         end
         ST_CLEAR: begin
            mem_addr_c = cnt;
            mem_we_c   = 1'b1;
            cnt_next   = cnt + AW'(1);
            if (cnt == CNT_LAST) begin
               state_next = ST_ARB;
               done_next  = 1'b1;
            end
         end
         default: state_next = ST_ARB;
      endcase
      // A read granted this cycle returns next cycle, even if CLEAR starts.
      rvalid_next = gnt_c & ~bus.we;
      busy_next   = (state_next == ST_CLEAR);
   end

   assign bus.gnt        = gnt_c;
   assign bus.mem_addr   = mem_addr_c;
   assign bus.mem_data   = mem_data_c;
   assign bus.mem_we     = mem_we_c;
   assign bus.rvalid     = rvalid_q;
   assign bus.rdata      = bus.mem_q;
   assign bus.clear_busy = busy_q;
   assign bus.clear_done = done_q;

endmodule

// File: tb/tb_bram_arbiter.sv
// Self-checking bench for bram_arbiter: vector table, directed scenarios, random traffic.
module tb_bram_arbiter;
   import bram_arbiter_pkg::*;

   localparam int unsigned DEPTH = 2 ** AW;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   bram_arbiter_if bus();

   bram_arbiter dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Behavioural BRAM: registered read, read-before-write.
   logic [DW-1:0] bram [DEPTH];
   always @(posedge clk) begin
      if (bus.mem_we) bram[bus.mem_addr] <= bus.mem_data;
      bus.mem_q <= bram[bus.mem_addr];
   end

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic idle();
      bus.req         = '0;
      bus.we          = '0;
      bus.addr        = '0;
      bus.wdata       = '0;
      bus.clear_start = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Present a single access from requester r (others idle).
   task automatic access(input int r, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      idle();
      bus.req[r]             = 1'b1;
      bus.we[r]              = w;
      bus.addr[r*AW +: AW]   = a;
      bus.wdata[r*DW +: DW]  = d;
   endtask

   task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
      access(0, 1'b1, a, d);
      next_cycle();
      idle();
   endtask

   task automatic rd_check(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp);
      access(0, 1'b0, a, '0);
      @(negedge clk);
      chk(name, 32'(bus.gnt), 32'h1);
      next_cycle();
      idle();
      @(negedge clk);
      chk(name, 32'(bus.rvalid), 32'h1);
      chk(name, 32'(bus.rdata), 32'(exp));
      next_cycle();
   endtask

   function automatic int oh_idx(input logic [2:0] g);
      for (int i = 0; i < 3; i++) if (g[i]) return i;
      return 0;
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      idle();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   typedef struct {
      logic [2:0] req;
      logic [2:0] we;
      logic [2:0] gnt;
      logic       mwe;
   } vec_t;

   vec_t tbl[17];

   // Reference model state for random traffic.
   logic [DW-1:0] shadow [DEPTH];
   bit            pend_v  [3];
   bit            pend_we [3];
   logic [AW-1:0] pend_a  [3];
   logic [DW-1:0] pend_d  [3];

   initial begin
      #500000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [2:0]    prev_rv;
      int            busy_n, done_n, done_at, bad, gnt_busy, post, w;
      int            last_m, win;
      logic [2:0]    exp_rv;
      logic [DW-1:0] exp_rd;
      logic [2:0]    rq, wq;

      tbl[0]  = '{3'b111, 3'b000, 3'b001, 1'b0};
      tbl[1]  = '{3'b111, 3'b000, 3'b010, 1'b0};
      tbl[2]  = '{3'b111, 3'b000, 3'b100, 1'b0};
      tbl[3]  = '{3'b111, 3'b000, 3'b001, 1'b0};
      tbl[4]  = '{3'b111, 3'b000, 3'b010, 1'b0};
      tbl[5]  = '{3'b111, 3'b000, 3'b100, 1'b0};
      tbl[6]  = '{3'b000, 3'b111, 3'b000, 1'b0};
      tbl[7]  = '{3'b010, 3'b010, 3'b010, 1'b1};
      tbl[8]  = '{3'b011, 3'b000, 3'b001, 1'b0};
      tbl[9]  = '{3'b011, 3'b001, 3'b010, 1'b0};
      tbl[10] = '{3'b101, 3'b100, 3'b100, 1'b1};
      tbl[11] = '{3'b101, 3'b000, 3'b001, 1'b0};
      tbl[12] = '{3'b100, 3'b000, 3'b100, 1'b0};
      tbl[13] = '{3'b110, 3'b000, 3'b010, 1'b0};
      tbl[14] = '{3'b110, 3'b000, 3'b100, 1'b0};
      tbl[15] = '{3'b001, 3'b000, 3'b001, 1'b0};
      tbl[16] = '{3'b001, 3'b000, 3'b001, 1'b0};

      // Reset state.
      reset = 1'b1;
      idle();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_gnt", 32'(bus.gnt), 32'h0);
      chk("rst_rvalid", 32'(bus.rvalid), 32'h0);
      chk("rst_busy", 32'(bus.clear_busy), 32'h0);
      chk("rst_done", 32'(bus.clear_done), 32'h0);
      chk("rst_mem_we", 32'(bus.mem_we), 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Vector table: fairness and priority from a known pointer.
      prev_rv = '0;
      for (int k = 0; k < 17; k++) begin
         bus.req   = tbl[k].req;
         bus.we    = tbl[k].we;
         bus.addr  = {AW'(12), AW'(11), AW'(10)};
         bus.wdata = {DW'(16'h0C0C), DW'(16'h0B0B), DW'(16'h0A0A)};
         @(negedge clk);
         chk("tbl_gnt", 32'(bus.gnt), 32'(tbl[k].gnt));
         chk("tbl_mem_we", 32'(bus.mem_we), 32'(tbl[k].mwe));
         chk("tbl_rvalid", 32'(bus.rvalid), 32'(prev_rv));
         if (tbl[k].gnt != 3'b000)
            chk("tbl_mem_addr", 32'(bus.mem_addr), 32'(10 + oh_idx(tbl[k].gnt)));
         prev_rv = tbl[k].gnt & ~tbl[k].we;
         next_cycle();
      end
      idle();

      // Single write then read back.
      access(0, 1'b1, AW'(5), DW'(16'h1234));
      @(negedge clk);
      chk("wr_gnt", 32'(bus.gnt), 32'h1);
      chk("wr_mem_we", 32'(bus.mem_we), 32'h1);
      chk("wr_mem_addr", 32'(bus.mem_addr), 32'd5);
      chk("wr_mem_data", 32'(bus.mem_data), 32'h1234);
      next_cycle();
      idle();
      @(negedge clk);
      chk("wr_no_rvalid", 32'(bus.rvalid), 32'h0);
      next_cycle();
      rd_check("wr_readback", AW'(5), DW'(16'h1234));

      // Read pipelining across two requesters.
      write_word(AW'(3), DW'(30));
      write_word(AW'(4), DW'(40));
      access(1, 1'b0, AW'(3), '0);
      @(negedge clk);
      chk("pipe_gnt1", 32'(bus.gnt), 32'h2);
      next_cycle();
      access(2, 1'b0, AW'(4), '0);
      @(negedge clk);
      chk("pipe_gnt2", 32'(bus.gnt), 32'h4);
      chk("pipe_rv1", 32'(bus.rvalid), 32'h2);
      chk("pipe_rd1", 32'(bus.rdata), 32'd30);
      next_cycle();
      idle();
      @(negedge clk);
      chk("pipe_rv2", 32'(bus.rvalid), 32'h4);
      chk("pipe_rd2", 32'(bus.rdata), 32'd40);
      next_cycle();

      // Clear with a grant in the start cycle and a re-pulse mid-clear.
      for (int i = 0; i < 32; i++) write_word(AW'(i), DW'(i));
      write_word(AW'(500), DW'(16'hBEEF));
      access(0, 1'b0, AW'(7), '0);
      bus.clear_start = 1'b1;
      @(negedge clk);
      chk("clr_start_gnt", 32'(bus.gnt), 32'h1);
      next_cycle();
      bus.clear_start = 1'b0;
      bus.req   = 3'b111;
      bus.we    = 3'b111;
      bus.addr  = {AW'(902), AW'(901), AW'(900)};
      bus.wdata = {DW'(16'hEEEE), DW'(16'hDDDD), DW'(16'hCCCC)};
      busy_n = 0; done_n = 0; done_at = -1; bad = 0; gnt_busy = 0; post = 0;
      for (int c = 0; c < 1200 && post < 4; c++) begin
         @(negedge clk);
         if (c == 0) begin
            chk("clr_owed_rvalid", 32'(bus.rvalid), 32'h1);
            chk("clr_owed_rdata", 32'(bus.rdata), 32'd7);
         end
         if (bus.clear_busy) begin
            if (bus.gnt != '0) gnt_busy++;
            if (!bus.mem_we || bus.mem_addr != AW'(busy_n) || bus.mem_data != '0) bad++;
            busy_n++;
         end
         if (bus.clear_done) begin
            done_n++;
            if (done_at < 0) done_at = busy_n;
            if (bus.clear_busy || bus.gnt == '0) bad++;
         end
         if (done_n > 0) post++;
         next_cycle();
         bus.clear_start = (busy_n == 500);
      end
      idle();
      chk("clr_busy_cycles", 32'(busy_n), 32'd1024);
      chk("clr_done_count", 32'(done_n), 32'd1);
      chk("clr_done_at", 32'(done_at), 32'd1024);
      chk("clr_bad_cycles", 32'(bad), 32'd0);
      chk("clr_gnt_busy", 32'(gnt_busy), 32'd0);
      for (int i = 0; i < 32; i++) rd_check("clr_readback", AW'(i), '0);
      rd_check("clr_read500", AW'(500), '0);

      // Reset at clear cycle 100.
      write_word(AW'(500), DW'(16'hBEEF));
      bus.clear_start = 1'b1;
      next_cycle();
      bus.clear_start = 1'b0;
      repeat (100) next_cycle();
      @(negedge clk);
      chk("mid_busy_pre", 32'(bus.clear_busy), 32'h1);
      reset = 1'b1;
      #1;
      chk("mid_busy_rst", 32'(bus.clear_busy), 32'h0);
      chk("mid_done_rst", 32'(bus.clear_done), 32'h0);
      next_cycle();
      reset = 1'b0;
      bus.req = 3'b111;
      @(negedge clk);
      chk("mid_last_reset", 32'(bus.gnt), 32'h1);
      next_cycle();
      idle();
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (bus.clear_done || bus.clear_busy) bad++;
         next_cycle();
      end
      chk("mid_no_done", 32'(bad), 32'd0);
      rd_check("mid_word500", AW'(500), DW'(16'hBEEF));

      // Next clear restarts at address 0 and runs to completion.
      bus.clear_start = 1'b1;
      next_cycle();
      bus.clear_start = 1'b0;
      @(negedge clk);
      chk("restart_addr", 32'(bus.mem_addr), 32'd0);
      chk("restart_we", 32'(bus.mem_we), 32'h1);
      w = 0;
      for (w = 0; w < 1100; w++) begin
         next_cycle();
         @(negedge clk);
         if (bus.clear_done) break;
      end
      chk("restart_done_wait", 32'(w), 32'd1023);
      next_cycle();

      // Random traffic against a reference model (memory now all zero).
      do_reset();
      for (int i = 0; i < int'(DEPTH); i++) shadow[i] = '0;
      for (int i = 0; i < 3; i++) pend_v[i] = 1'b0;
      last_m = 2;
      exp_rv = '0;
      exp_rd = '0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int i = 0; i < 3; i++) begin
            if (!pend_v[i] && $urandom_range(0, 99) < 60) begin
               pend_v[i]  = 1'b1;
               pend_we[i] = ($urandom_range(0, 1) == 1);
               pend_a[i]  = AW'($urandom_range(0, 15));
               pend_d[i]  = DW'($urandom);
            end
         end
         rq = '0;
         wq = '0;
         for (int i = 0; i < 3; i++) begin
            rq[i] = pend_v[i];
            wq[i] = pend_we[i];
            bus.addr[i*AW +: AW]  = pend_a[i];
            bus.wdata[i*DW +: DW] = pend_d[i];
         end
         bus.req = rq;
         bus.we  = wq;
         win = -1;
         for (int k = 1; k <= 3; k++) begin
            if (win < 0 && pend_v[(last_m + k) % 3]) win = (last_m + k) % 3;
         end
         @(negedge clk);
         chk("rnd_gnt", 32'(bus.gnt), (win < 0) ? 32'h0 : (32'h1 << win));
         chk("rnd_mem_we", 32'(bus.mem_we), (win >= 0 && pend_we[win]) ? 32'h1 : 32'h0);
         chk("rnd_rvalid", 32'(bus.rvalid), 32'(exp_rv));
         if (exp_rv != '0) chk("rnd_rdata", 32'(bus.rdata), 32'(exp_rd));
         exp_rv = '0;
         if (win >= 0) begin
            chk("rnd_mem_addr", 32'(bus.mem_addr), 32'(pend_a[win]));
            if (pend_we[win]) begin
               chk("rnd_mem_data", 32'(bus.mem_data), 32'(pend_d[win]));
               shadow[pend_a[win]] = pend_d[win];
            end else begin
               exp_rv[win] = 1'b1;
               exp_rd      = shadow[pend_a[win]];
            end
            last_m      = win;
            pend_v[win] = 1'b0;
         end
         next_cycle();
      end
      idle();
      @(negedge clk);
      chk("rnd_final_rvalid", 32'(bus.rvalid), 32'(exp_rv));
      if (exp_rv != '0) chk("rnd_final_rdata", 32'(bus.rdata), 32'(exp_rd));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
